// File: rtl/sub_float_seq.sv
// rtl/sub_float_seq.sv - multi-cycle IEEE-754 single-precision subtractor (diff = a - b)
`timescale 1ns/1ps
module sub_float_seq #(
    parameter int GUARD_BITS   = 3,
    parameter bit FLUSH_DENORM = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] diff,
    output logic        busy
);
    localparam int SW   = 24 + GUARD_BITS;
    localparam int CNTW = $clog2(SW + 1);
    localparam logic [31:0] QNAN = 32'h7FC00000;

    typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, OP, NORM, PACK, DONE} state_t;
    state_t state, state_nx;

    logic [31:0]     a_r, b_r;
    logic            x_sign, y_sign;
    logic [8:0]      x_exp;
    logic [SW:0]     x_sig;
    logic [SW-1:0]   y_sig;
    logic [CNTW-1:0] shift_cnt;
    logic            res_zero, res_inf;
    logic [31:0]     diff_r;

    // b_r already carries the inverted sign, so everything below is an addition of a and -b
    logic [7:0] a_exp, b_exp;
    logic       a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    assign a_exp  = a_r[30:23];
    assign b_exp  = b_r[30:23];
    assign a_nan  = (a_exp == 8'hFF) && (a_r[22:0] != 23'd0);
    assign b_nan  = (b_exp == 8'hFF) && (b_r[22:0] != 23'd0);
    assign a_inf  = (a_exp == 8'hFF) && (a_r[22:0] == 23'd0);
    assign b_inf  = (b_exp == 8'hFF) && (b_r[22:0] == 23'd0);
    assign a_zero = (a_exp == 8'd0) && (FLUSH_DENORM || (a_r[22:0] == 23'd0));
    assign b_zero = (b_exp == 8'd0) && (FLUSH_DENORM || (b_r[22:0] == 23'd0));

    logic        special;
    logic [31:0] special_val;

    always_comb begin
        special     = 1'b1;
        special_val = QNAN;
        if (a_nan || b_nan)
            special_val = QNAN;
        else if (a_inf && b_inf && (a_r[31] != b_r[31]))
            special_val = QNAN;
        else if (a_inf)
            special_val = a_r;
        else if (b_inf)
            special_val = b_r;
        else if (a_zero && b_zero)
            special_val = {a_r[31] & b_r[31], 31'd0};
        else if (a_zero)
            special_val = b_r;
        else if (b_zero)
            special_val = a_r;
        else
            special = 1'b0;
    end

    // Both operands are normal here, so comparing {exp, frac} orders the magnitudes
    logic            b_larger;
    logic [31:0]     x_op, y_op;
    logic [7:0]      exp_gap;
    logic [CNTW-1:0] shift_init;

    assign b_larger   = b_r[30:0] > a_r[30:0];
    assign x_op       = b_larger ? b_r : a_r;
    assign y_op       = b_larger ? a_r : b_r;
    assign exp_gap    = x_op[30:23] - y_op[30:23];
    assign shift_init = (exp_gap >= 8'(SW)) ? CNTW'(SW) : exp_gap[CNTW-1:0];

    logic [SW:0] mag;
    logic [8:0]  exp_inc, exp_dec;

    assign mag     = (x_sign == y_sign) ? (x_sig + {1'b0, y_sig}) : (x_sig - {1'b0, y_sig});
    assign exp_inc = x_exp + 9'd1;
    assign exp_dec = x_exp - 9'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (in_valid) state_nx = UNPACK;
            UNPACK: state_nx = special ? DONE : ALIGN;
            ALIGN:  if (shift_cnt <= CNTW'(1)) state_nx = OP;
            OP:     state_nx = (mag == '0) ? DONE : NORM;
            // leave once the leading one lands in place after this cycle's shift
            NORM:   if (x_sig[SW] || x_sig[SW-1] || x_sig[SW-2] || (exp_dec == 9'd0))
                        state_nx = PACK;
            PACK:   state_nx = DONE;
            DONE:   if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r       <= '0;
            b_r       <= '0;
            x_sign    <= 1'b0;
            y_sign    <= 1'b0;
            x_exp     <= '0;
            x_sig     <= '0;
            y_sig     <= '0;
            shift_cnt <= '0;
            res_zero  <= 1'b0;
            res_inf   <= 1'b0;
            diff_r    <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_r      <= a;
                    b_r      <= {~b[31], b[30:0]};
                    res_zero <= 1'b0;
                    res_inf  <= 1'b0;
                end
                UNPACK: begin
                    x_sign    <= x_op[31];
                    y_sign    <= y_op[31];
                    x_exp     <= {1'b0, x_op[30:23]};
                    x_sig     <= {2'b01, x_op[22:0], {GUARD_BITS{1'b0}}};
                    y_sig     <= {1'b1, y_op[22:0], {GUARD_BITS{1'b0}}};
                    shift_cnt <= shift_init;
                    if (special)
                        diff_r <= special_val;
                end
                ALIGN: if (shift_cnt != '0) begin
                    y_sig     <= {1'b0, y_sig[SW-1:2], y_sig[1] | y_sig[0]};
                    shift_cnt <= shift_cnt - CNTW'(1);
                end
                OP: begin
                    x_sig <= mag;
                    if (mag == '0)
                        diff_r <= '0;
                end
                NORM: begin
                    if (x_sig[SW]) begin
                        x_sig   <= {1'b0, x_sig[SW:2], x_sig[1] | x_sig[0]};
                        x_exp   <= exp_inc;
                        res_inf <= (exp_inc >= 9'd255);
                    end else if (!x_sig[SW-1]) begin
                        x_sig    <= {x_sig[SW-1:0], 1'b0};
                        x_exp    <= exp_dec;
                        res_zero <= (exp_dec == 9'd0);
                    end
                end
                PACK: begin
                    if (res_zero)
                        diff_r <= {x_sign, 31'd0};
                    else if (res_inf)
                        diff_r <= {x_sign, 8'hFF, 23'd0};
                    else
                        diff_r <= {x_sign, x_exp[7:0], x_sig[SW-2:GUARD_BITS]};
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign diff      = diff_r;

endmodule

// File: tb/tb_sub_float_seq.sv
// tb/tb_sub_float_seq.sv - self-checking bench for sub_float_seq
`timescale 1ns/1ps
module tb_sub_float_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [31:0] a_i, b_i, diff;

    int          n_checks = 0;
    int          n_errors = 0;
    logic        exp_busy = 1'b0;
    logic [31:0] exp_q[$];

    localparam int NV = 18;
    localparam logic [31:0] VA [NV] = '{
        32'h40400000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h7F7FFFFF,
        32'h7F800000, 32'h7FC00001, 32'h80000000, 32'h00000000, 32'h00000000, 32'h40000000,
        32'hFF800000, 32'h00800000, 32'h00000001, 32'h3F800000, 32'h40A00000, 32'h41200000};
    localparam logic [31:0] VB [NV] = '{
        32'h3F800000, 32'h3F800000, 32'hBF800000, 32'h3F7FFFFF, 32'h30800000, 32'hFF7FFFFF,
        32'h7F800000, 32'h12345678, 32'h00000000, 32'h00000000, 32'h3F800000, 32'h40400000,
        32'h3F800000, 32'h00C00000, 32'h3F800000, 32'h7F800000, 32'h3F000000, 32'h41100000};
    localparam logic [31:0] VD [NV] = '{
        32'h40000000, 32'h00000000, 32'h40000000, 32'h33800000, 32'h3F7FFFFF, 32'h7F800000,
        32'h7FC00000, 32'h7FC00000, 32'h80000000, 32'h00000000, 32'hBF800000, 32'hBF800000,
        32'hFF800000, 32'h80000000, 32'hBF800000, 32'hFF800000, 32'h40900000, 32'h3F800000};
    localparam int VL [NV] = '{6, 0, 0, 0, 0, 0, 2, 2, 2, 2, 2, 0, 2, 0, 2, 2, 8, 8};

    sub_float_seq #(.GUARD_BITS(3), .FLUSH_DENORM(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a_i), .b(b_i), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .busy(busy));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", name, got, want);
        end
    endtask

    // Exact-value reference: align on a wide integer grid, subtract, then truncate
    function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y);
        logic         sa, sb, rs;
        int           ea, eb, emin, p, re;
        logic [319:0] ma, mb, r;
        sa = x[31];
        sb = ~y[31];
        ea = int'(x[30:23]);
        eb = int'(y[30:23]);
        if ((ea == 255 && x[22:0] != 0) || (eb == 255 && y[22:0] != 0)) return 32'h7FC00000;
        if (ea == 255 && eb == 255) return (sa == sb) ? {sa, 8'hFF, 23'd0} : 32'h7FC00000;
        if (ea == 255) return {sa, 8'hFF, 23'd0};
        if (eb == 255) return {sb, 8'hFF, 23'd0};
        if (ea == 0 && eb == 0) return {sa & sb, 31'd0};
        if (ea == 0) return {sb, y[30:0]};
        if (eb == 0) return x;
        emin = (ea < eb) ? ea : eb;
        ma = '0;
        mb = '0;
        ma[23:0] = {1'b1, x[22:0]};
        mb[23:0] = {1'b1, y[22:0]};
        ma = ma << (ea - emin);
        mb = mb << (eb - emin);
        if (sa == sb) begin
            r = ma + mb; rs = sa;
        end else if (ma >= mb) begin
            r = ma - mb; rs = sa;
        end else begin
            r = mb - ma; rs = sb;
        end
        if (r == '0) return 32'h0;
        p = 0;
        for (int i = 0; i < 320; i++) if (r[i]) p = i;
        re = emin + p - 23;
        if (re >= 255) return {rs, 8'hFF, 23'd0};
        if (re <= 0) return {rs, 31'd0};
        if (p >= 23) r = r >> (p - 23);
        else r = r << (23 - p);
        return {rs, 8'(re), r[22:0]};
    endfunction

    task automatic run_op(input logic [31:0] va, input logic [31:0] vb, input int lat, input int stall);
        logic [31:0] e;
        int t;
        e = model(va, vb);
        out_ready = (stall == 0);
        a_i = va;
        b_i = vb;
        in_valid = 1'b1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        exp_busy = 1'b1;
        a_i = $urandom;
        b_i = $urandom;
        t = 1;
        while (!out_valid && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        in_valid = 1'b0;
        if (!out_valid) begin
            n_checks++;
            n_errors++;
            $display("FAIL out_valid_timeout: a=%08h b=%08h no result after %0d cycles", va, vb, t);
            rst = 1'b1;
            exp_q.delete();
            exp_busy = 1'b0;
            @(posedge clk); #1;
            rst = 1'b0;
            out_ready = 1'b1;
            return;
        end
        if (lat != 0) chk($sformatf("latency_%08h_%08h", va, vb), 32'(t), 32'(lat));
        for (int i = 0; i < stall; i++) begin
            chk("stall_diff", diff, e);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        exp_busy = 1'b0;
        chk("post_out_valid", 32'(out_valid), 32'd0);
        chk("post_in_ready", 32'(in_ready), 32'd1);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("in_ready", 32'(in_ready), 32'(!exp_busy));
            if (!exp_busy) chk("idle_out_valid", 32'(out_valid), 32'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL spurious_result: diff=%08h with no operation pending", diff);
                end else begin
                    chk("diff", diff, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a_i = '0;
        b_i = '0;
        #2;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_diff", diff, 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < NV; i++) chk($sformatf("model_%0d", i), model(VA[i], VB[i]), VD[i]);
        for (int i = 0; i < NV; i++) run_op(VA[i], VB[i], VL[i], 0);
        run_op(32'h40400000, 32'h3F800000, 6, 10);

        // abort a long alignment with an asynchronous reset
        a_i = 32'h3F800000;
        b_i = 32'h30800000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        exp_busy = 1'b1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_align_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        exp_busy = 1'b0;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_diff", diff, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (70) @(posedge clk);
        #1;
        chk("after_abort_out_valid", 32'(out_valid), 32'd0);
        run_op(32'h40A00000, 32'h3F000000, 8, 0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
